uart_core: RTL and testbench

Parametrised UART with independent RX and TX FIFOs, programmable oversampling divisor, optional parity and sticky error flags. It replaces the fixed 8-bit receiver/transmitter/buffer cluster on the processor bus: the CPU pushes bytes through a write port, pops received bytes through a read port, and polls a status word. It is the only block in the design that touches the serial pins.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_fifo.sv | 48 ++++
 rtl/uart_core.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: line FSM states, register map, status bit positions, sticky error flags.
// Declarations only; no latency or backpressure of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  localparam int ST_RX_EMPTY   = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_TX_FULL    = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_PARITY_ERR = 6;
  localparam int ST_RX_CNT_LSB = 8;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 7;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic overrun;
  } err_flags_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with show-ahead dout; push/pop take effect on the clock edge, flags and count follow it.
// Push when full and pop when empty are ignored; the extra pointer MSB separates full from empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_core.sv
// UART with RX/TX FIFOs behind a 2-bit register port; r_data is one cycle after re, rx byte visible 1 cycle after its stop sample.
// TX pushes beyond FIFO capacity are dropped silently; RX bytes arriving to a full FIFO are dropped and flag overrun.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 54,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [1:0]           addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [15:0]          r_data,
  output logic                 rx_empty,
  output logic                 tx_full,
  output logic                 err
);
  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(SAMPLE_POINT);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);
  localparam bit         HAS_PAR   = (PARITY_EN != 0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic             rx_meta_q, rx_sync_q;

  uart_state_e          rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d, rx_bit_end;
  err_flags_t           rx_ev, err_q, err_d;

  uart_state_e          tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d, tx_bcnt_q, tx_bcnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_bit_end, tx_q, tx_d;

  logic                 rx_push, rx_pop, rx_full, tx_push, tx_pop, tx_empty, status_rd;
  logic [DATA_BITS-1:0] rx_dout, tx_dout;
  logic [CW-1:0]        rx_count, unused_tx_count;
  logic [15:0]          r_data_q, r_data_d, status_w;
  logic [8:0]           rx_cnt_ext;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(w_data),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
  );

  always_comb begin
    tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Receiver: tick counter restarts at the start edge so every later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    rx_ev      = '0;
    rx_bit_end = tick && (rx_tcnt_q == LAST_TICK);
    if (tick && rx_state_q != IDLE) rx_tcnt_d = rx_tcnt_q + 1'b1;
    case (rx_state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = START;
          rx_tcnt_d  = '0;
        end
      end
      START: begin
        if (tick && rx_tcnt_q == MID_TICK) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bcnt_d  = rx_bcnt_q + 1'b1;
          if (rx_bcnt_q == LAST_BIT) rx_state_d = HAS_PAR ? PAR : STOP;
        end
      end
      PAR: begin
        if (rx_bit_end) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_bit_end) begin
          rx_state_d = IDLE;
          if (!rx_sync_q)                                  rx_ev.frame_err  = 1'b1;
          else if (HAS_PAR && (rx_par_q != (^rx_shift_q ^ ODD))) rx_ev.parity_err = 1'b1;
          else if (rx_full)                                rx_ev.overrun    = 1'b1;
          else                                             rx_push          = 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_bit_end = tick && (tx_tcnt_q == LAST_TICK);
    if (tick && tx_state_q != IDLE) tx_tcnt_d = tx_tcnt_q + 1'b1;
    case (tx_state_q)
      IDLE: begin
        if (!tx_empty) tx_state_d = START;
      end
      START: begin
        if (tx_bit_end) begin
          tx_state_d = DATA;
          tx_bcnt_d  = '0;
        end
      end
      DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bcnt_d  = tx_bcnt_q + 1'b1;
          if (tx_bcnt_q == LAST_BIT) tx_state_d = HAS_PAR ? PAR : STOP;
        end
      end
      PAR: begin
        if (tx_bit_end) tx_state_d = STOP;
      end
      STOP: begin
        if (tx_bit_end) tx_state_d = tx_empty ? IDLE : START;
      end
      default: tx_state_d = IDLE;
    endcase
    // Loading on entry to START covers both the idle start and back-to-back frames.
    if (tx_state_d == START && tx_state_q != START) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_dout;
      tx_par_d   = ^tx_dout ^ ODD;
      tx_tcnt_d  = '0;
    end
    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_shift_d[0];
      PAR:     tx_d = tx_par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    tx_push    = we && (addr == ADDR_DATA);
    rx_pop     = re && (addr == ADDR_DATA);
    status_rd  = re && (addr == ADDR_STATUS);
    rx_cnt_ext = 9'(rx_count);
    status_w                         = '0;
    status_w[ST_RX_EMPTY]            = rx_empty;
    status_w[ST_RX_FULL]             = rx_full;
    status_w[ST_TX_EMPTY]            = tx_empty;
    status_w[ST_TX_FULL]             = tx_full;
    status_w[ST_OVERRUN]             = err_q.overrun;
    status_w[ST_FRAME_ERR]           = err_q.frame_err;
    status_w[ST_PARITY_ERR]          = err_q.parity_err;
    status_w[ST_RX_CNT_LSB +: 8]     = rx_cnt_ext[8] ? 8'hFF : rx_cnt_ext[7:0];
    r_data_d = r_data_q;
    if (re) begin
      case (addr)
        ADDR_DATA:   if (!rx_empty) r_data_d = 16'(rx_dout);
        ADDR_STATUS: r_data_d = status_w;
        default:     r_data_d = '0;
      endcase
    end
    // A status read clears the flags, but an error raised in the same cycle survives.
    err_d = status_rd ? '0 : err_q;
    err_d = err_flags_t'(err_d | rx_ev);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      tx_state_q <= IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      err_q      <= '0;
      r_data_q   <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      r_data_q   <= r_data_d;
    end
  end

  assign tx     = tx_q;
  assign r_data = r_data_q;
  assign err    = |err_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: an 8N1 depth-16 instance (with optional loopback) and an 8E1 depth-4 instance.
// Expected bytes go into scoreboard queues when driven and are popped when the DUT produces them.
`timescale 1ns/1ps
module tb_uart_core;
  import uart_pkg::*;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        loop_en = 1'b0, a_rx_drv = 1'b1, a_rx, a_tx;
  logic [1:0]  a_addr = '0;
  logic        a_we = 1'b0, a_re = 1'b0;
  logic [7:0]  a_wdata = '0;
  logic [15:0] a_rdata;
  logic        a_rx_empty, a_tx_full, a_err;
  assign a_rx = loop_en ? a_tx : a_rx_drv;

  logic        b_rx = 1'b1, b_tx;
  logic [1:0]  b_addr = '0;
  logic        b_we = 1'b0, b_re = 1'b0;
  logic [7:0]  b_wdata = '0;
  logic [15:0] b_rdata;
  logic        b_rx_empty, b_tx_full, b_err;

  uart_core #(.DATA_BITS(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(a_rx), .tx(a_tx), .addr(a_addr), .we(a_we), .re(a_re),
    .w_data(a_wdata), .r_data(a_rdata), .rx_empty(a_rx_empty), .tx_full(a_tx_full), .err(a_err)
  );

  uart_core #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(b_rx), .tx(b_tx), .addr(b_addr), .we(b_we), .re(b_re),
    .w_data(b_wdata), .r_data(b_rdata), .rx_empty(b_rx_empty), .tx_full(b_tx_full), .err(b_err)
  );

  int n_pass = 0, n_total = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_status(input int rx_cnt, input int depth, input int tx_cnt,
                                             input bit ovr, input bit fe, input bit pe);
    logic [15:0] s;
    s = '0;
    s[0] = (rx_cnt == 0);
    s[1] = (rx_cnt == depth);
    s[2] = (tx_cnt == 0);
    s[3] = (tx_cnt == depth);
    s[4] = ovr;
    s[5] = fe;
    s[6] = pe;
    s[15:8] = 8'((rx_cnt > 255) ? 255 : rx_cnt);
    return s;
  endfunction

  task automatic bus_write(input bit sel, input logic [1:0] ad, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin b_addr = ad; b_wdata = d; b_we = 1'b1; end
    else     begin a_addr = ad; a_wdata = d; a_we = 1'b1; end
    @(negedge clk);
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] ad, output logic [15:0] d);
    @(negedge clk);
    if (sel) begin b_addr = ad; b_re = 1'b1; end
    else     begin a_addr = ad; a_re = 1'b1; end
    @(negedge clk);
    a_re = 1'b0;
    b_re = 1'b0;
    d = sel ? b_rdata : a_rdata;
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) b_rx = v; else a_rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input int stop_low_clks);
    @(negedge clk);
    drive_bit(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CLKS);
    if (with_par) drive_bit(sel, par_bit, BIT_CLKS);
    if (stop_low_clks > 0) drive_bit(sel, 1'b0, stop_low_clks);
    drive_bit(sel, 1'b1, BIT_CLKS);
  endtask

  // Waits for a start bit on dut_a's tx, then samples each of the 10 bits near its centre.
  task automatic get_tx_frame(output logic [9:0] bits, output bit got, input int timeout);
    got  = 1'b0;
    bits = '0;
    for (int i = 0; i < timeout && !got; i++) begin
      @(negedge clk);
      if (a_tx === 1'b0) got = 1'b1;
    end
    if (got) begin
      repeat (31) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        bits[k] = a_tx;
        if (k < 9) repeat (BIT_CLKS) @(negedge clk);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [9:0]  bits, bits0;
  logic [15:0] rd;
  logic [7:0]  e, d;
  bit          got, got0, low_seen;
  int          cnt, nframes;
  bit          ovr;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_tx", a_tx, 1);
    check("rst_rdata", a_rdata, 0);
    check("rst_rx_empty", a_rx_empty, 1);
    check("rst_tx_full", a_tx_full, 0);
    check("rst_err", a_err, 0);
    check("rst_b_rx_empty", b_rx_empty, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single 8N1 frame, also bounds the start latency.
    tx_exp_q.push_back(8'hA5);
    bus_write(0, ADDR_DATA, 8'hA5);
    get_tx_frame(bits, got, 8);
    check("tx_start_latency", got, 1);
    if (got) begin
      e = tx_exp_q.pop_front();
      check("tx_frame_a5", bits, {1'b1, e, 1'b0});
    end
    repeat (40) @(negedge clk);
    bus_read(0, ADDR_STATUS, rd);
    check("tx_status_after", rd, exp_status(0, 16, 0, 0, 0, 0));

    // Loopback.
    loop_en = 1'b1;
    rx_exp_q.push_back(8'h00); bus_write(0, ADDR_DATA, 8'h00);
    rx_exp_q.push_back(8'hFF); bus_write(0, ADDR_DATA, 8'hFF);
    rx_exp_q.push_back(8'h3C); bus_write(0, ADDR_DATA, 8'h3C);
    repeat (3 * 10 * BIT_CLKS + 200) @(negedge clk);
    check("loop_err", a_err, 0);
    bus_read(0, ADDR_STATUS, rd);
    check("loop_status", rd, exp_status(3, 16, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      bus_read(0, ADDR_DATA, rd);
      e = rx_exp_q.pop_front();
      check("loop_data", rd, {8'h00, e});
    end
    check("loop_rx_empty", a_rx_empty, 1);
    bus_read(0, ADDR_DATA, rd);
    check("pop_empty_holds", rd, 16'h003C);
    loop_en = 1'b0;

    // Framing error on 0x55.
    send_frame(0, 8'h55, 0, 1'b0, 44);
    check("fe_err", a_err, 1);
    check("fe_rx_empty", a_rx_empty, 1);
    bus_read(0, ADDR_STATUS, rd);
    check("fe_status", rd, exp_status(0, 16, 0, 0, 1, 0));
    bus_read(0, ADDR_STATUS, rd);
    check("fe_status_clr", rd, exp_status(0, 16, 0, 0, 0, 0));
    check("fe_err_clr", a_err, 0);

    // Short glitch on rx.
    @(negedge clk);
    a_rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_err", a_err, 0);
    bus_read(0, ADDR_STATUS, rd);
    check("glitch_status", rd, exp_status(0, 16, 0, 0, 0, 0));

    // Overrun on the depth-4 even-parity instance.
    cnt = 0;
    ovr = 0;
    for (int i = 0; i < 5; i++) begin
      d = 8'h12 + 8'(i * 8'h22);
      if (cnt < 4) begin rx_exp_q.push_back(d); cnt++; end
      else ovr = 1;
      send_frame(1, d, 1, ^d, 0);
    end
    repeat (10) @(negedge clk);
    check("ovr_err", b_err, 1);
    bus_read(1, ADDR_STATUS, rd);
    check("ovr_status", rd, exp_status(cnt, 4, 0, ovr, 0, 0));
    bus_read(1, ADDR_STATUS, rd);
    check("ovr_status_clr", rd, exp_status(cnt, 4, 0, 0, 0, 0));
    check("ovr_err_clr", b_err, 0);
    for (int i = 0; i < 4; i++) begin
      bus_read(1, ADDR_DATA, rd);
      e = rx_exp_q.pop_front();
      check("ovr_data", rd, {8'h00, e});
    end
    check("ovr_drained", b_rx_empty, 1);

    // Wrong even-parity bit.
    d = 8'h5A;
    send_frame(1, d, 1, ~(^d), 0);
    check("pe_err", b_err, 1);
    check("pe_rx_empty", b_rx_empty, 1);
    bus_read(1, ADDR_STATUS, rd);
    check("pe_status", rd, exp_status(0, 4, 0, 0, 0, 1));
    bus_read(1, ADDR_STATUS, rd);
    check("reserved_read", 32'(rd), 32'(exp_status(0, 4, 0, 0, 0, 0)));
    bus_read(1, 2'd2, rd);
    check("addr2_reads_zero", rd, 16'h0000);

    // Overfill TX FIFO while a frame is in flight.
    tx_exp_q.push_back(8'h11);
    cnt = 0;
    fork
      get_tx_frame(bits0, got0, 20);
      begin
        bus_write(0, ADDR_DATA, 8'h11);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          d = 8'(i * 13 + 1);
          if (cnt < 16) begin tx_exp_q.push_back(d); cnt++; end
          bus_write(0, ADDR_DATA, d);
        end
        check("ovf_tx_full", a_tx_full, 1);
      end
    join
    nframes = 0;
    check("ovf_first_got", got0, 1);
    if (got0) begin
      nframes++;
      e = tx_exp_q.pop_front();
      check("ovf_first_frame", bits0, {1'b1, e, 1'b0});
    end
    for (int i = 0; i < 16; i++) begin
      get_tx_frame(bits, got, 800);
      if (got) begin
        nframes++;
        e = tx_exp_q.pop_front();
        check("ovf_frame", bits, {1'b1, e, 1'b0});
      end
    end
    get_tx_frame(bits, got, 2000);
    check("ovf_no_extra", got, 0);
    check("ovf_frame_count", nframes, 17);

    // Reset in the middle of 0x81.
    bus_write(0, ADDR_DATA, 8'h81);
    repeat (200) @(negedge clk);
    check("rst_mid_pre_tx", a_tx, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", a_tx, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1) low_seen = 1'b1;
    end
    check("rst_mid_tx_idle", low_seen, 0);
    bus_read(0, ADDR_STATUS, rd);
    check("rst_mid_status", rd, exp_status(0, 16, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
